// File: rtl/umi_arb_pkg.sv
// Shared constants and helpers for the UMI round-robin arbiter.
// Holds the packet width default, port maximum and index width.
package umi_arb_pkg;

   localparam int UMI_UW_DEF = 256;
   localparam int UMI_N_MAX  = 8;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/umi_rr_select.sv
// Round-robin priority search: first requester after last_i wins.
// Returns both a one-hot grant and its encoded index.
module umi_rr_select
   import umi_arb_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]          req_i,
   input  logic [idx_w(N)-1:0]   last_i,
   output logic [N-1:0]          gnt_o,
   output logic [idx_w(N)-1:0]   idx_o
);

   localparam int IW = idx_w(N);

   logic [IW-1:0] pi;

   // Walk from the farthest offset back to the nearest so the
   // nearest requester after last_i is the one left standing.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      pi    = '0;
      for (int k = N; k >= 1; k--) begin
         pi = IW'((int'(last_i) + k) % N);
         if (req_i[pi]) begin
            gnt_o     = '0;
            gnt_o[pi] = 1'b1;
            idx_o     = pi;
         end
      end
   end

endmodule

// File: rtl/umi_rr_arbiter.sv
// N-port UMI round-robin merge with a single output register stage.
// Drain and reload share a cycle, so full throughput needs no skid.
module umi_rr_arbiter
   import umi_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int UW = UMI_UW_DEF
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic [N-1:0]          umi_in_valid,
   input  logic [N*UW-1:0]       umi_in_packet,
   output logic [N-1:0]          umi_in_ready,
   output logic                  umi_out_valid,
   output logic [UW-1:0]         umi_out_packet,
   input  logic                  umi_out_ready,
   output logic [idx_w(N)-1:0]   grant_id,
   output logic [31:0]           pkt_count
);

   localparam int IW = idx_w(N);

   if (N < 2 || N > UMI_N_MAX) begin : g_bad_n
      $error("umi_rr_arbiter: N out of range");
   end

   logic          vld_q, vld_d;
   logic [UW-1:0] pkt_q, pkt_d;
   logic [IW-1:0] id_q, id_d;
   logic [IW-1:0] last_q, last_d;
   logic [31:0]   cnt_q, cnt_d;

   logic [N-1:0]  gnt;
   logic [IW-1:0] sel;
   logic          load_en;
   logic          load;

   umi_rr_select #(.N(N)) u_sel (
      .req_i  (umi_in_valid),
      .last_i (last_q),
      .gnt_o  (gnt),
      .idx_o  (sel)
   );

   assign load_en      = !vld_q || umi_out_ready;
   assign load         = load_en && (|umi_in_valid) && !nreset;
   assign umi_in_ready = (load_en && !nreset) ? gnt : '0;

   always_comb begin
      vld_d  = vld_q;
      pkt_d  = pkt_q;
      id_d   = id_q;
      last_d = last_q;
      cnt_d  = cnt_q + {31'd0, vld_q & umi_out_ready};
      if (load) begin
         vld_d  = 1'b1;
         pkt_d  = umi_in_packet[int'(sel)*UW +: UW];
         id_d   = sel;
         last_d = sel;
      end else if (umi_out_ready) begin
         vld_d  = 1'b0;
      end
   end

   // last_q parks on N-1 so port 0 is first in line after reset.
   always_ff @(posedge clk) begin
      if (nreset) begin
         vld_q  <= 1'b0;
         pkt_q  <= '0;
         id_q   <= '0;
         last_q <= IW'(N - 1);
         cnt_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         pkt_q  <= pkt_d;
         id_q   <= id_d;
         last_q <= last_d;
         cnt_q  <= cnt_d;
      end
   end

   assign umi_out_valid  = vld_q;
   assign umi_out_packet = pkt_q;
   assign grant_id       = id_q;
   assign pkt_count      = cnt_q;

endmodule

// File: tb/tb_umi_rr_arbiter.sv
// Bench for umi_rr_arbiter: directed scenarios plus random traffic
// checked each cycle against a transaction-level model.
module tb_umi_rr_arbiter;

   localparam int N  = 4;
   localparam int UW = 64;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            nreset;
   logic [N-1:0]    in_valid;
   logic [N*UW-1:0] in_pkt;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic [UW-1:0]   out_pkt;
   logic            out_ready;
   logic [IW-1:0]   gid;
   logic [31:0]     cnt;

   umi_rr_arbiter #(.N(N), .UW(UW)) dut (
      .clk            (clk),
      .nreset         (nreset),
      .umi_in_valid   (in_valid),
      .umi_in_packet  (in_pkt),
      .umi_in_ready   (in_ready),
      .umi_out_valid  (out_valid),
      .umi_out_packet (out_pkt),
      .umi_out_ready  (out_ready),
      .grant_id       (gid),
      .pkt_count      (cnt)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   bit            m_vld;
   logic [UW-1:0] m_pkt;
   int            m_id;
   int            m_last;
   logic [31:0]   m_cnt;
   int            waitc[N];

   function automatic int pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         int p;
         p = (last + k) % N;
         if (v[p]) return p;
      end
      return -1;
   endfunction

   task automatic cmp(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_cycle();
      int w;
      logic [N-1:0] er;
      w  = pick(in_valid, m_last);
      er = '0;
      if (!nreset && (!m_vld || out_ready) && w >= 0)
         er = N'(1) << w;
      cmp("in_ready", 64'(in_ready), 64'(er));
      cmp("out_valid", 64'(out_valid), 64'(m_vld));
      if (m_vld) begin
         cmp("out_packet", 64'(out_pkt), 64'(m_pkt));
         cmp("grant_id", 64'(gid), 64'(m_id));
      end
      cmp("pkt_count", 64'(cnt), 64'(m_cnt));
      // A continuously requesting port may see at most N-1 others served.
      for (int p = 0; p < N; p++) begin
         if (nreset || !in_valid[p]) begin
            waitc[p] = 0;
         end else if (|(in_ready & in_valid)) begin
            if (in_ready[p]) begin
               waitc[p] = 0;
            end else begin
               waitc[p]++;
               cmp("fairness", 64'(waitc[p] <= N - 1), 64'(1));
            end
         end
      end
   endtask

   task automatic model_edge();
      int w;
      bit le;
      if (nreset) begin
         m_vld  = 1'b0;
         m_pkt  = '0;
         m_id   = 0;
         m_last = N - 1;
         m_cnt  = '0;
         return;
      end
      le = !m_vld || out_ready;
      if (m_vld && out_ready) m_cnt = m_cnt + 32'd1;
      w = pick(in_valid, m_last);
      if (le && w >= 0) begin
         m_vld  = 1'b1;
         m_pkt  = in_pkt[w*UW +: UW];
         m_id   = w;
         m_last = w;
      end else if (out_ready) begin
         m_vld = 1'b0;
      end
   endtask

   task automatic step();
      #1;
      check_cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic rand_pkts();
      for (int p = 0; p < N; p++)
         in_pkt[p*UW +: UW] = {$urandom, $urandom};
   endtask

   int seq_a[5] = '{0, 1, 2, 3, 0};
   int seq_b[4] = '{1, 3, 0, 1};
   logic [UW-1:0] held;

   initial begin
      nreset    = 1'b1;
      in_valid  = '0;
      in_pkt    = '0;
      out_ready = 1'b0;
      for (int p = 0; p < N; p++) waitc[p] = 0;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      step();
      step();
      cmp("rst_valid", 64'(out_valid), 64'(0));
      cmp("rst_count", 64'(cnt), 64'(0));
      cmp("rst_gid", 64'(gid), 64'(0));
      cmp("rst_pkt", 64'(out_pkt), 64'(0));

      // Two contenders alternate; eight packets counted after drain.
      nreset    = 1'b0;
      in_valid  = 4'b0011;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rand_pkts();
         step();
         cmp("alt_gid", 64'(gid), 64'(i % 2));
      end
      in_valid = '0;
      step();
      cmp("alt_count", 64'(cnt), 64'(8));
      cmp("alt_drained", 64'(out_valid), 64'(0));

      // Single requester on port 1.
      rand_pkts();
      in_pkt[UW +: UW] = 64'hA5;
      in_valid = 4'b0010;
      #1;
      cmp("p1_rdy0", 64'(in_ready[0]), 64'(0));
      step();
      cmp("p1_pkt", 64'(out_pkt), 64'hA5);
      cmp("p1_gid", 64'(gid), 64'(1));
      in_valid = '0;
      step();

      // Back-pressure hold then release with same-cycle reload.
      rand_pkts();
      held     = in_pkt[0 +: UW];
      in_valid = 4'b0001;
      step();
      out_ready = 1'b0;
      in_valid  = 4'b0101;
      for (int i = 0; i < 5; i++) begin
         rand_pkts();
         step();
         cmp("hold_pkt", 64'(out_pkt), 64'(held));
         cmp("hold_gid", 64'(gid), 64'(0));
         #1;
         cmp("hold_rdy", 64'(in_ready), 64'(0));
      end
      out_ready = 1'b1;
      step();
      cmp("reload_valid", 64'(out_valid), 64'(1));
      cmp("reload_gid", 64'(gid), 64'(2));
      in_valid = '0;
      step();
      step();

      // Four-way rotation, then port 2 drops out.
      nreset = 1'b1;
      step();
      nreset   = 1'b0;
      in_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         rand_pkts();
         step();
         cmp("rot4_gid", 64'(gid), 64'(seq_a[i]));
      end
      in_valid = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         rand_pkts();
         step();
         cmp("skip2_gid", 64'(gid), 64'(seq_b[i]));
      end

      // Reset while a packet is held.
      cmp("pre_rst_valid", 64'(out_valid), 64'(1));
      nreset = 1'b1;
      step();
      cmp("mid_rst_valid", 64'(out_valid), 64'(0));
      cmp("mid_rst_count", 64'(cnt), 64'(0));
      nreset   = 1'b0;
      in_valid = 4'b1111;
      rand_pkts();
      step();
      cmp("post_rst_gid", 64'(gid), 64'(0));
      cmp("post_rst_valid", 64'(out_valid), 64'(1));

      // Counter wrap.
      in_valid  = '0;
      out_ready = 1'b0;
      step();
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      m_cnt = 32'hFFFF_FFFF;
      cmp("wrap_pre", 64'(cnt), 64'hFFFF_FFFF);
      out_ready = 1'b1;
      step();
      cmp("wrap_count", 64'(cnt), 64'(0));

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         nreset    = ($urandom_range(0, 199) == 0);
         in_valid  = N'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         rand_pkts();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
